// File: rtl/alu_pkg.sv
// Shared types and constants for the LC-3 operate-instruction issue controller.
// Holds opcode values, ALU select encodings, FSM states and condition-code helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    typedef enum logic [1:0] {
        SEL_ADD  = 2'b00,
        SEL_AND  = 2'b01,
        SEL_NOT  = 2'b10,
        SEL_PASS = 2'b11
    } alu_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        WB     = 2'b11
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic alu_sel_t sel_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return SEL_ADD;
            OP_AND:  return SEL_AND;
            OP_NOT:  return SEL_NOT;
            default: return SEL_PASS;
        endcase
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15])
            return NZP_N;
        else if (v == 16'h0000)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// Register file: synchronous write, synchronous clear, three combinational read ports.
// Reads return pre-write contents within the write cycle.
module reg_file_8x16
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we_i,
    input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic [$clog2(NUM_REGS)-1:0] raddr1_i,
    output logic [WIDTH-1:0]            rdata1_o,
    input  logic [$clog2(NUM_REGS)-1:0] raddr2_i,
    output logic [WIDTH-1:0]            rdata2_o,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr_i,
    output logic [WIDTH-1:0]            dbg_data_o
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = regs_q[raddr1_i];
    assign rdata2_o   = regs_q[raddr2_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ADD/AND/NOT instruction at a time to an external combinational ALU,
// then writes the result back to the register file and updates NZP.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_d0,
    output logic [WIDTH-1:0] alu_d1,
    output logic [1:0]       alu_select,
    input  logic [WIDTH-1:0] alu_dout,
    output logic             done,
    output logic             illegal,
    output logic [2:0]       nzp,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           state_q;
    alu_sel_t         sel_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] d0_q;
    logic [WIDTH-1:0] d1_q;
    logic [2:0]       nzp_q;
    logic             done_q;
    logic             illegal_q;

    logic [3:0]       op;
    logic [2:0]       dr;
    logic [2:0]       sr1;
    logic [2:0]       sr2;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;

    assign op       = instr_q[15:12];
    assign dr       = instr_q[11:9];
    assign sr1      = instr_q[8:6];
    assign sr2      = instr_q[2:0];
    assign imm_sext = {{(WIDTH-5){instr_q[4]}}, instr_q[4:0]};

    reg_file_8x16 #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH)
    ) u_rf (
        .clk        (clk),
        .reset      (reset),
        .we_i       (state_q == WB),
        .waddr_i    (dr),
        .wdata_i    (result_q),
        .raddr1_i   (sr1),
        .rdata1_o   (rs1_data),
        .raddr2_i   (sr2),
        .rdata2_o   (rs2_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // Control FSM; operand/select registers are non-idle only while in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= SEL_PASS;
            d0_q      <= '0;
            d1_q      <= '0;
            nzp_q     <= NZP_Z;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        illegal_q <= !op_supported(instr[15:12]);
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    if (op_supported(op)) begin
                        d0_q    <= rs1_data;
                        if (op == OP_NOT)
                            d1_q <= '0;
                        else if (instr_q[5])
                            d1_q <= imm_sext;
                        else
                            d1_q <= rs2_data;
                        sel_q   <= sel_of(op);
                        state_q <= EXEC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    sel_q   <= SEL_PASS;
                    d0_q    <= '0;
                    d1_q    <= '0;
                    done_q  <= 1'b1;
                    state_q <= WB;
                end
                WB: begin
                    nzp_q   <= nzp_of(result_q);
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Instruction and result words carry no reset; they are only consumed after being loaded.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && instr_valid)
            instr_q <= instr;
        if (state_q == EXEC)
            result_q <= alu_dout;
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_d0      = d0_q;
    assign alu_d1      = d1_q;
    assign alu_select  = sel_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign nzp         = nzp_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU beside the DUT.
// Expected values are hand-computed from the instruction encodings.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_d0;
    logic [15:0] alu_d1;
    logic [1:0]  alu_select;
    logic [15:0] alu_dout;
    logic        done;
    logic        illegal;
    logic [2:0]  nzp;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NUM_REGS(8), .WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_d0      (alu_d0),
        .alu_d1      (alu_d1),
        .alu_select  (alu_select),
        .alu_dout    (alu_dout),
        .done        (done),
        .illegal     (illegal),
        .nzp         (nzp),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // External ALU
    always_comb begin
        alu_dout = alu_d0;
        case (alu_select)
            2'b00:   alu_dout = alu_d0 + alu_d1;
            2'b01:   alu_dout = alu_d0 & alu_d1;
            2'b10:   alu_dout = ~alu_d0;
            default: alu_dout = alu_d0;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (instr_ready !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", {15'd0, instr_ready}, 16'h0001);
    endtask

    // Handshake at the edge following the drive; checks every cycle up to t+4.
    task automatic run_op(input logic [15:0] ins, input logic hold, input logic [15:0] alt,
                          input logic [1:0] sel, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [2:0] dr, input logic [15:0] oldv,
                          input logic [15:0] newv, input logic [2:0] nzp_e);
        wait_ready();
        dbg_addr    = dr;
        instr_valid = 1'b1;
        instr       = ins;
        @(negedge clk);
        if (hold) instr = alt;
        else instr_valid = 1'b0;
        chk("dec_ready", {15'd0, instr_ready}, 16'h0000);
        chk("dec_illegal", {15'd0, illegal}, 16'h0000);
        @(negedge clk);
        chk("exec_sel", {14'd0, alu_select}, {14'd0, sel});
        chk("exec_d0", alu_d0, d0);
        chk("exec_d1", alu_d1, d1);
        chk("exec_done", {15'd0, done}, 16'h0000);
        if (hold) chk("exec_ready", {15'd0, instr_ready}, 16'h0000);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("wb_done", {15'd0, done}, 16'h0001);
        chk("wb_sel", {14'd0, alu_select}, 16'h0003);
        chk("wb_d0", alu_d0, 16'h0000);
        chk("wb_dbg_old", dbg_data, oldv);
        if (hold) chk("wb_ready", {15'd0, instr_ready}, 16'h0000);
        @(negedge clk);
        chk("post_done", {15'd0, done}, 16'h0000);
        chk("post_ready", {15'd0, instr_ready}, 16'h0001);
        chk("post_rdr", dbg_data, newv);
        chk("post_nzp", {13'd0, nzp}, {13'd0, nzp_e});
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) begin
            dbg_addr = a[2:0];
            #1;
            chk($sformatf("rst_r%0d", a), dbg_data, 16'h0000);
        end
        chk("rst_nzp", {13'd0, nzp}, 16'h0002);
        chk("rst_ready", {15'd0, instr_ready}, 16'h0001);
        chk("rst_sel", {14'd0, alu_select}, 16'h0003);
        chk("rst_done", {15'd0, done}, 16'h0000);
        chk("rst_d0", alu_d0, 16'h0000);
        chk("rst_d1", alu_d1, 16'h0000);
        @(negedge clk);

        // R1 = R0 + 5
        run_op(16'h1225, 1'b0, 16'h0, 2'b00, 16'h0000, 16'h0005, 3'd1, 16'h0000, 16'h0005, 3'b001);
        // R2 = R1 + (-6)
        run_op(16'h147A, 1'b0, 16'h0, 2'b00, 16'h0005, 16'hFFFA, 3'd2, 16'h0000, 16'hFFFF, 3'b100);
        // R3 = R2 & R1
        run_op(16'h5681, 1'b0, 16'h0, 2'b01, 16'hFFFF, 16'h0005, 3'd3, 16'h0000, 16'h0005, 3'b001);
        // R4 = ~R2
        run_op(16'h98BF, 1'b0, 16'h0, 2'b10, 16'hFFFF, 16'h0000, 3'd4, 16'h0000, 16'h0000, 3'b010);

        // Unsupported opcode
        wait_ready();
        instr_valid = 1'b1;
        instr       = 16'h0000;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ill_pulse", {15'd0, illegal}, 16'h0001);
        chk("ill_ready_busy", {15'd0, instr_ready}, 16'h0000);
        chk("ill_done", {15'd0, done}, 16'h0000);
        @(negedge clk);
        chk("ill_clear", {15'd0, illegal}, 16'h0000);
        chk("ill_ready", {15'd0, instr_ready}, 16'h0001);
        chk("ill_done2", {15'd0, done}, 16'h0000);
        chk("ill_nzp", {13'd0, nzp}, 16'h0002);
        dbg_addr = 3'd0; #1; chk("ill_r0", dbg_data, 16'h0000);
        dbg_addr = 3'd1; #1; chk("ill_r1", dbg_data, 16'h0005);
        dbg_addr = 3'd2; #1; chk("ill_r2", dbg_data, 16'hFFFF);
        dbg_addr = 3'd3; #1; chk("ill_r3", dbg_data, 16'h0005);
        @(negedge clk);

        // R5 = R0 + (-1), with a different instruction held on the bus while busy
        run_op(16'h1A3F, 1'b1, 16'h1C01, 2'b00, 16'h0000, 16'hFFFF, 3'd5, 16'h0000, 16'hFFFF, 3'b100);
        @(negedge clk);
        chk("busy_no_done", {15'd0, done}, 16'h0000);
        dbg_addr = 3'd6; #1; chk("busy_r6", dbg_data, 16'h0000);
        @(negedge clk);

        // Reset asserted during EXEC of R1 = R0 + 5
        wait_ready();
        instr_valid = 1'b1;
        instr       = 16'h1225;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_sel", {14'd0, alu_select}, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_done", {15'd0, done}, 16'h0000);
        chk("mid_ready", {15'd0, instr_ready}, 16'h0001);
        chk("mid_nzp", {13'd0, nzp}, 16'h0002);
        chk("mid_sel", {14'd0, alu_select}, 16'h0003);
        dbg_addr = 3'd1; #1; chk("mid_r1", dbg_data, 16'h0000);
        @(negedge clk);
        chk("mid_done2", {15'd0, done}, 16'h0000);
        chk("mid_r1b", dbg_data, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
